// File: rtl/ecc_des_sequencer.sv
// rtl/ecc_des_sequencer.sv - host-side command sequencer for the ECC/3DES controller start/done protocol
// One command in flight; a single watchdog timer spans every wait state of that command.
module ecc_des_sequencer #(
  parameter int TIMEOUT = 1023,
  parameter int LEN_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             cmd_ready,
  output logic             rsp_valid,
  output logic             rsp_err,
  input  logic             rsp_ready,
  output logic             busy,
  output logic             ecc_start1,
  output logic             ecc_start2,
  output logic             des_start,
  input  logic             ecc1_done,
  input  logic             ecc2_done,
  input  logic             des_done,
  input  logic [163:0]     PuX,
  input  logic [163:0]     PuY,
  output logic [163:0]     pub_x,
  output logic [163:0]     pub_y
);
  localparam int            TW  = $clog2(TIMEOUT + 2);
  localparam logic [TW-1:0] TMO = TW'(TIMEOUT);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ECC_GO    = 3'd1;
  localparam logic [2:0] S_ECC_WAIT  = 3'd2;
  localparam logic [2:0] S_DES_KEY   = 3'd3;
  localparam logic [2:0] S_DES_DATA  = 3'd4;
  localparam logic [2:0] S_DES_DRAIN = 3'd5;
  localparam logic [2:0] S_RESP      = 3'd6;

  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic [1:0]       r_op;
  logic [LEN_W-1:0] r_cmd_len;
  logic [LEN_W-1:0] r_len;
  logic [TW-1:0]    r_timer;
  logic             r_err;
  logic             w_next_err;
  logic             r_ecc_start1;
  logic             r_ecc_start2;
  logic             r_des_start;
  logic [163:0]     r_pub_x;
  logic [163:0]     r_pub_y;
  logic             w_accept;
  logic             w_tmo;
  logic             w_ecc_hit;
  logic             w_timing;

  assign w_accept  = cmd_valid && (r_state == S_IDLE);
  assign w_tmo     = (r_timer >= TMO);
  assign w_ecc_hit = ((r_op == 2'b01) && ecc1_done) || ((r_op == 2'b10) && ecc2_done);
  assign w_timing  = (r_state == S_ECC_WAIT) || (r_state == S_DES_KEY) || (r_state == S_DES_DRAIN);

  // A done seen in the same cycle as the timeout always takes priority.
  always_comb begin
    w_next     = r_state;
    w_next_err = r_err;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next_err = 1'b0;
          case (cmd_op)
            2'b01, 2'b10: w_next = S_ECC_GO;
            2'b11:        w_next = S_DES_KEY;
            default: begin
              w_next     = S_RESP;
              w_next_err = 1'b1;
            end
          endcase
        end
      end
      S_ECC_GO: w_next = S_ECC_WAIT;
      S_ECC_WAIT: begin
        if (w_ecc_hit || w_tmo) begin
          w_next     = S_RESP;
          w_next_err = !w_ecc_hit;
        end
      end
      S_DES_KEY: begin
        if (des_done) begin
          w_next = S_DES_DATA;
        end else if (w_tmo) begin
          w_next     = S_RESP;
          w_next_err = 1'b1;
        end
      end
      S_DES_DATA: begin
        if (r_len == '0) w_next = S_DES_DRAIN;
      end
      S_DES_DRAIN: begin
        if (!des_done || w_tmo) begin
          w_next     = S_RESP;
          w_next_err = des_done;
        end
      end
      S_RESP: begin
        if (rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_op         <= 2'b00;
      r_cmd_len    <= '0;
      r_len        <= '0;
      r_timer      <= '0;
      r_err        <= 1'b0;
      r_ecc_start1 <= 1'b0;
      r_ecc_start2 <= 1'b0;
      r_des_start  <= 1'b0;
      r_pub_x      <= '0;
      r_pub_y      <= '0;
    end else begin
      r_state      <= w_next;
      r_err        <= w_next_err;
      r_ecc_start1 <= w_accept && (cmd_op == 2'b01);
      r_ecc_start2 <= w_accept && (cmd_op == 2'b10);
      r_des_start  <= (w_next == S_DES_KEY) || (w_next == S_DES_DATA);
      if (w_accept) begin
        r_op      <= cmd_op;
        r_cmd_len <= cmd_len;
        r_timer   <= '0;
      end else if (w_timing) begin
        r_timer <= r_timer + 1'b1;
      end
      if ((r_state == S_DES_KEY) && des_done) begin
        r_len <= r_cmd_len;
      end else if ((r_state == S_DES_DATA) && (r_len != '0)) begin
        r_len <= r_len - 1'b1;
      end
      if ((r_state == S_ECC_WAIT) && (r_op == 2'b01) && ecc1_done) begin
        r_pub_x <= PuX;
        r_pub_y <= PuY;
      end
    end
  end

  assign cmd_ready  = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign rsp_valid  = (r_state == S_RESP);
  assign rsp_err    = r_err;
  assign ecc_start1 = r_ecc_start1;
  assign ecc_start2 = r_ecc_start2;
  assign des_start  = r_des_start;
  assign pub_x      = r_pub_x;
  assign pub_y      = r_pub_y;
endmodule

// File: tb/tb_ecc_des_sequencer.sv
// tb/tb_ecc_des_sequencer.sv - randomized scoreboard bench for ecc_des_sequencer
// Expected responses, response timing and start run lengths come from cycle-count arithmetic on each command.
module tb_ecc_des_sequencer;
  localparam int TMO = 100;
  localparam int LW  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd_op = 2'b00;
  logic [LW-1:0] cmd_len = '0;
  logic          cmd_ready, rsp_valid, rsp_err, busy;
  logic          rsp_ready = 1'b0;
  logic          ecc_start1, ecc_start2, des_start;
  logic          ecc1_done = 1'b0, ecc2_done = 1'b0, des_done = 1'b0;
  logic [163:0]  PuX = '0, PuY = '0;
  logic [163:0]  pub_x, pub_y;

  ecc_des_sequencer #(.TIMEOUT(TMO), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_len(cmd_len),
    .cmd_ready(cmd_ready), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_ready(rsp_ready),
    .busy(busy), .ecc_start1(ecc_start1), .ecc_start2(ecc_start2), .des_start(des_start),
    .ecc1_done(ecc1_done), .ecc2_done(ecc2_done), .des_done(des_done),
    .PuX(PuX), .PuY(PuY), .pub_x(pub_x), .pub_y(pub_y)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         err;
    logic [163:0] px;
    logic [163:0] py;
  } rsp_t;

  rsp_t         exp_q[$];
  int           checks = 0, errors = 0;
  int           n_push = 0, n_pop = 0;
  int           cyc = 0, last_rise = -1;
  int           des_run = 0, ecc_run = 0, des_cnt = 0, ecc_cnt = 0, start_cycles = 0;
  int           rr_mode = 0;
  logic         prev_rv = 1'b0;
  logic [163:0] m_px = '0, m_py = '0;

  always @(posedge clk) cyc++;

  always begin
    @(posedge clk);
    #2;
    case (rr_mode)
      0:       rsp_ready = ($urandom_range(0, 3) != 0);
      1:       rsp_ready = 1'b0;
      default: rsp_ready = 1'b1;
    endcase
  end

  // Response monitor: pops the scoreboard on every completed handshake.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if ((32'(ecc_start1) + 32'(ecc_start2) + 32'(des_start)) > 1) begin
        errors++;
        $display("FAIL onehot_starts: got %b%b%b expected at most one high", ecc_start1, ecc_start2, des_start);
      end
      if (rsp_valid && !prev_rv) begin
        last_rise = cyc;
        checks++;
        if (ecc_start1 || ecc_start2 || des_start) begin
          errors++;
          $display("FAIL starts_in_resp: got %b%b%b expected 000", ecc_start1, ecc_start2, des_start);
        end
      end
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp: got response err=%b expected none", rsp_err);
        end else begin
          rsp_t e;
          e = exp_q.pop_front();
          if (rsp_err !== e.err || pub_x !== e.px || pub_y !== e.py) begin
            errors++;
            $display("FAIL rsp_data: got err=%b x=%h y=%h expected err=%b x=%h y=%h",
                     rsp_err, pub_x, pub_y, e.err, e.px, e.py);
          end
        end
        n_pop++;
      end
      if (ecc_start1 || ecc_start2 || des_start) start_cycles++;
    end
    prev_rv = rsp_valid;
    if (des_start) des_cnt++;
    else if (des_cnt != 0) begin des_run = des_cnt; des_cnt = 0; end
    if (ecc_start1 || ecc_start2) ecc_cnt++;
    else if (ecc_cnt != 0) begin ecc_run = ecc_cnt; ecc_cnt = 0; end
  end

  initial begin
    #3000000;
    $display("FAIL global_watchdog: got no finish expected finish");
    $fatal(1);
  end

  function automatic logic [163:0] rnd164();
    logic [191:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[163:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic err);
    rsp_t e;
    e.err = err; e.px = m_px; e.py = m_py;
    exp_q.push_back(e);
    n_push++;
  endtask

  // Returns the cycle number right after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [LW-1:0] len, output int c0);
    int b = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_len = len;
    while (!cmd_ready && b < 200) begin tick(); b++; end
    chk_i("cmd_ready_before_issue", int'(cmd_ready), 1);
    tick();
    cmd_valid = 1'b0; cmd_op = 2'($urandom()); cmd_len = LW'($urandom());
    c0 = cyc;
  endtask

  task automatic wait_rsp();
    int b = 0;
    while (n_pop < n_push && b < 3000) begin tick(); b++; end
    checks++;
    if (n_pop < n_push) begin
      errors++;
      $display("FAIL rsp_timeout: got %0d responses expected %0d", n_pop, n_push);
      n_pop = n_push;
      exp_q.delete();
    end
  endtask

  // d < 0: the matching done never arrives. stray: cycle of the non-matching done (0 = none).
  task automatic run_ecc(input logic [1:0] op, input int d, input int stray,
                         input logic [163:0] px, input logic [163:0] py);
    int c0, r, n;
    logic err;
    err = (d < 0) || (d > TMO + 1);
    if (!err && op == 2'b01) begin m_px = px; m_py = py; end
    push_exp(err);
    r = err ? TMO + 2 : d + 1;
    ecc_run = -1;
    issue(op, LW'($urandom()), c0);
    chk_i("ecc_start_at_go", int'(op == 2'b01 ? ecc_start1 : ecc_start2), 1);
    n = (d > stray) ? d : stray;
    for (int i = 1; i <= n; i++) begin
      tick();
      ecc1_done = (op == 2'b01 && i == d) || (op == 2'b10 && i == stray);
      ecc2_done = (op == 2'b10 && i == d) || (op == 2'b01 && i == stray);
      PuX = (op == 2'b01 && i == d) ? px : rnd164();
      PuY = (op == 2'b01 && i == d) ? py : rnd164();
    end
    tick();
    ecc1_done = 1'b0; ecc2_done = 1'b0;
    wait_rsp();
    chk_i("ecc_rsp_cycle", last_rise, c0 + r);
    chk_i("ecc_start_len", ecc_run, 1);
  endtask

  // k: cycles from first des_start to des_done rising (k > TMO: never). h: extra cycles des_done holds.
  task automatic run_des(input int len, input int k, input int h);
    int s, r, run, ds, m, i0;
    logic err;
    if (k > TMO) begin
      err = 1'b1; r = TMO + 1; run = TMO + 1;
    end else begin
      run = k + len + 2;
      ds  = k + len + 2;
      m   = (h - len - 1 > 0) ? h - len - 1 : 0;
      i0  = (TMO - k - 1 > 0) ? TMO - k - 1 : 0;
      if (i0 < m) begin err = 1'b1; r = ds + i0 + 1; end
      else begin err = 1'b0; r = ds + m + 1; end
    end
    push_exp(err);
    des_run = -1;
    issue(2'b11, LW'(len), s);
    chk_i("des_start_at_key", int'(des_start), 1);
    chk_i("busy_in_des", int'(busy), 1);
    if (k <= TMO) begin
      for (int i = 0; i < k; i++) tick();
      des_done = 1'b1;
      for (int i = 0; i <= h; i++) tick();
      des_done = 1'b0;
    end
    wait_rsp();
    chk_i("des_rsp_cycle", last_rise, s + r);
    chk_i("des_start_len", des_run, run);
  endtask

  task automatic run_illegal();
    int c0, sc;
    sc = start_cycles;
    push_exp(1'b1);
    issue(2'b00, LW'($urandom()), c0);
    wait_rsp();
    chk_i("illegal_rsp_cycle", last_rise, c0);
    chk_i("illegal_no_start", start_cycles - sc, 0);
  endtask

  initial begin
    int c0, sc, pops;
    repeat (3) @(negedge clk);
    chk_i("rst_cmd_ready", int'(cmd_ready), 1);
    chk_i("rst_busy", int'(busy), 0);
    chk_i("rst_rsp_valid", int'(rsp_valid), 0);
    chk_i("rst_rsp_err", int'(rsp_err), 0);
    chk_i("rst_starts", int'({ecc_start1, ecc_start2, des_start}), 0);
    chk_i("rst_pub_zero", int'(pub_x == '0 && pub_y == '0), 1);
    rst = 1'b0;
    tick();

    run_ecc(2'b01, 20, 0, 164'h5A5, 164'h3C3);
    run_ecc(2'b10, 12, 5, rnd164(), rnd164());
    run_des(5, 51, 48);
    run_ecc(2'b01, -1, 0, rnd164(), rnd164());
    run_ecc(2'b01, TMO + 1, 0, rnd164(), rnd164());
    run_ecc(2'b10, TMO + 2, 3, rnd164(), rnd164());
    run_des(0, 3, 10);
    run_des(3, TMO, 2);
    run_des(2, 10, 200);
    run_des(4, TMO + 5, 0);

    // Illegal op held under back-pressure with a competing command waiting.
    rr_mode = 1;
    sc = start_cycles;
    push_exp(1'b1);
    issue(2'b00, 8'd0, c0);
    cmd_valid = 1'b1; cmd_op = 2'b01;
    for (int i = 0; i < 10; i++) begin
      chk_i("bp_rsp_valid", int'(rsp_valid), 1);
      chk_i("bp_cmd_ready", int'(cmd_ready), 0);
      chk_i("bp_rsp_err", int'(rsp_err), 1);
      tick();
    end
    cmd_valid = 1'b0;
    rr_mode = 2;
    wait_rsp();
    rr_mode = 0;
    chk_i("bp_no_start", start_cycles - sc, 0);

    // Reset while streaming DES data: no response, starts drop without a clock edge.
    pops = n_pop;
    issue(2'b11, 8'd20, c0);
    repeat (3) tick();
    des_done = 1'b1;
    repeat (2) tick();
    chk_i("mid_des_start_high", int'(des_start), 1);
    #2 rst = 1'b1;
    #1;
    chk_i("async_rst_des_start", int'(des_start), 0);
    chk_i("async_rst_busy", int'(busy), 0);
    des_done = 1'b0;
    m_px = '0; m_py = '0;
    tick();
    @(negedge clk);
    rst = 1'b0;
    repeat (10) tick();
    chk_i("post_rst_cmd_ready", int'(cmd_ready), 1);
    chk_i("post_rst_no_rsp", n_pop - pops, 0);

    for (int n = 0; n < 40; n++) begin
      int op, d, st, k, h, len;
      op = $urandom_range(0, 3);
      if (op == 0) begin
        run_illegal();
      end else if (op == 3) begin
        len = $urandom_range(0, 15);
        k   = ($urandom_range(0, 4) == 0) ? $urandom_range(TMO - 3, TMO + 3) : $urandom_range(0, 40);
        h   = ($urandom_range(0, 4) == 0) ? $urandom_range(60, 140) : $urandom_range(0, 30);
        run_des(len, k, h);
      end else begin
        d  = ($urandom_range(0, 3) == 0) ? $urandom_range(TMO - 2, TMO + 6) : $urandom_range(1, 60);
        st = ($urandom_range(0, 1) == 1 && d > 1) ? $urandom_range(1, d - 1) : 0;
        run_ecc(2'(op), d, st, rnd164(), rnd164());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
